// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP core: 16-state controller, IR, decode, BYPASS/IDCODE DRs, user DR selects, falling-edge TDO.
// Optional: define JTAG_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_tap_core #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(1),
  parameter logic [31:0]         IDCODE_VALUE = 32'h4A55_B001,
  parameter int                  IDCODE_INSTR = 1,
  parameter int                  USER_BASE    = 8,
  parameter int                  NUM_USER     = 2
) (
  input  logic                clk,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tstate,
  output logic [IR_WIDTH-1:0] instr,
  output logic [NUM_USER-1:0] user_sel,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  input  logic [NUM_USER-1:0] user_tdo,
  output logic                reset_n
);

  if (IR_WIDTH < 2) begin : g_chk_irw
    $error("jtag_tap_core: IR_WIDTH must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_chk_idv
    $error("jtag_tap_core: IDCODE_VALUE bit 0 must be 1");
  end
  if (IDCODE_INSTR < 0 || IDCODE_INSTR >= (1 << IR_WIDTH)) begin : g_chk_idi
    $error("jtag_tap_core: IDCODE_INSTR does not fit in IR_WIDTH");
  end
  if (NUM_USER < 1 || NUM_USER > 8 || USER_BASE + NUM_USER > (1 << IR_WIDTH)) begin : g_chk_usr
    $error("jtag_tap_core: user opcode range invalid");
  end

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PDR   = 4'h3,
    S_SELIR = 4'h4, S_UPDR  = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
    S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PIR   = 4'hB,
    S_IDLE  = 4'hC, S_UPIR  = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
  } state_t;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_INSTR = IR_WIDTH'(IDCODE_INSTR);
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR = '1;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic                r_bypass;
  logic                w_shift_ir;
  logic                w_capture_ir;
  logic                w_update_ir;
  logic                w_update_dr_st;
  logic                w_tlr;
  logic                w_sel_idcode;
  logic                w_sel_bypass;
  logic [NUM_USER-1:0] w_user_sel;
  logic                w_dr_lsb;

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) r_state <= S_TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:   w_next = tms ? S_TLR   : S_IDLE;
      S_IDLE:  w_next = tms ? S_SELDR : S_IDLE;
      S_SELDR: w_next = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = tms ? S_UPDR  : S_PDR;
      S_PDR:   w_next = tms ? S_EX2DR : S_PDR;
      S_EX2DR: w_next = tms ? S_UPDR  : S_SHDR;
      S_UPDR:  w_next = tms ? S_SELDR : S_IDLE;
      S_SELIR: w_next = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = tms ? S_UPIR  : S_PIR;
      S_PIR:   w_next = tms ? S_EX2IR : S_PIR;
      S_EX2IR: w_next = tms ? S_UPIR  : S_SHIR;
      S_UPIR:  w_next = tms ? S_SELDR : S_IDLE;
      default: w_next = S_TLR;
    endcase
  end

  always_comb begin
    capture_dr     = 1'b0;
    shift_dr       = 1'b0;
    w_update_dr_st = 1'b0;
    w_capture_ir   = 1'b0;
    w_shift_ir     = 1'b0;
    w_update_ir    = 1'b0;
    w_tlr          = 1'b0;
    case (r_state)
      S_CAPDR: capture_dr     = 1'b1;
      S_SHDR:  shift_dr       = 1'b1;
      S_UPDR:  w_update_dr_st = 1'b1;
      S_CAPIR: w_capture_ir   = 1'b1;
      S_SHIR:  w_shift_ir     = 1'b1;
      S_UPIR:  w_update_ir    = 1'b1;
      S_TLR:   w_tlr          = 1'b1;
      default: ;
    endcase
  end

  assign tstate    = r_state;
  assign update_dr = w_update_dr_st & ~clk;
  assign reset_n   = trst & ~w_tlr;

  always_ff @(posedge clk or negedge trst) begin
    if (!trst)             r_ir_sh <= IR_CAPTURE;
    else if (w_capture_ir) r_ir_sh <= IR_CAPTURE;
    else if (w_shift_ir)   r_ir_sh <= {tdi, r_ir_sh[IR_WIDTH-1:1]};
  end

  // instr only changes on the falling edge, so DR scans always see a stable decode
  always_ff @(negedge clk or negedge trst) begin
    if (!trst)            instr <= RST_INSTR;
    else if (w_tlr)       instr <= RST_INSTR;
    else if (w_update_ir) instr <= r_ir_sh;
  end

  always_comb begin
    w_sel_idcode = 1'b0;
    w_user_sel   = '0;
    if (instr != '1) begin
`ifdef JTAG_IDCODE_EN
      if (instr == IR_WIDTH'(IDCODE_INSTR)) w_sel_idcode = 1'b1;
`endif
      for (int i = 0; i < NUM_USER; i++) begin
        if (!w_sel_idcode && instr == IR_WIDTH'(USER_BASE + i)) w_user_sel[i] = 1'b1;
      end
    end
  end

  assign w_sel_bypass = ~w_sel_idcode & ~(|w_user_sel);
  assign user_sel     = w_user_sel;

  always_ff @(posedge clk or negedge trst) begin
    if (!trst)                          r_bypass <= 1'b0;
    else if (capture_dr && w_sel_bypass) r_bypass <= 1'b0;
    else if (shift_dr && w_sel_bypass)   r_bypass <= tdi;
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] r_idcode;

  always_ff @(posedge clk) begin
    if (capture_dr && w_sel_idcode)    r_idcode <= IDCODE_VALUE;
    else if (shift_dr && w_sel_idcode) r_idcode <= {tdi, r_idcode[31:1]};
  end
`endif

  always_comb begin
    w_dr_lsb = r_bypass;
    if (|w_user_sel) w_dr_lsb = |(w_user_sel & user_tdo);
`ifdef JTAG_IDCODE_EN
    if (w_sel_idcode) w_dr_lsb = r_idcode[0];
`endif
  end

  // TDO changes on the falling edge so the host samples it cleanly on the next rising edge
  always_ff @(negedge clk or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= w_shift_ir | shift_dr;
      if (w_shift_ir)    tdo <= r_ir_sh[0];
      else if (shift_dr) tdo <= w_dr_lsb;
      else               tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: queue-based TAP model checked every cycle, plus directed scans with literal expectations.
module tb_jtag_tap_core;
  localparam int          IR_W = 4;
  localparam logic [31:0] IDV  = 32'h4A55_B001;
  localparam int          IDI  = 1;
  localparam int          UB   = 8;
  localparam int          NU   = 2;
  localparam logic [3:0]  CAP  = 4'b0001;
`ifdef JTAG_IDCODE_EN
  localparam bit         HAS_ID = 1'b1;
  localparam logic [3:0] RST_I  = 4'h1;
`else
  localparam bit         HAS_ID = 1'b0;
  localparam logic [3:0] RST_I  = 4'hF;
`endif

  localparam int ST_SHDR = 2, ST_UPDR = 5, ST_CAPDR = 6, ST_SHIR = 10;
  localparam int ST_IDLE = 12, ST_UPIR = 13, ST_CAPIR = 14, ST_TLR = 15;

  // Successor state indexed by current state code, for tms=0 and tms=1
  int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  logic            clk = 1'b0;
  logic            trst = 1'b1;
  logic            tms = 1'b1;
  logic            tdi = 1'b0;
  logic [NU-1:0]   user_tdo = '0;
  logic            tdo, tdo_en, capture_dr, shift_dr, update_dr, reset_n;
  logic [3:0]      tstate;
  logic [IR_W-1:0] instr;
  logic [NU-1:0]   user_sel;

  jtag_tap_core #(
    .IR_WIDTH(IR_W), .IR_CAPTURE(CAP), .IDCODE_VALUE(IDV),
    .IDCODE_INSTR(IDI), .USER_BASE(UB), .NUM_USER(NU)
  ) dut (
    .clk(clk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tstate(tstate), .instr(instr), .user_sel(user_sel), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .user_tdo(user_tdo), .reset_n(reset_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // -1 bypass, -2 idcode, i>=0 user register i
  function automatic int dr_kind(input logic [3:0] ins);
    if (ins == 4'hF) return -1;
    if (HAS_ID && ins == 4'(IDI)) return -2;
    for (int i = 0; i < NU; i++) if (ins == 4'(UB + i)) return i;
    return -1;
  endfunction

  function automatic logic [NU-1:0] exp_sel(input logic [3:0] ins);
    int k;
    k = dr_kind(ins);
    return (k >= 0) ? NU'(1 << k) : '0;
  endfunction

  // Model: scan registers kept as LSB-first bit queues
  int         m_state = ST_TLR;
  logic [3:0] m_instr = RST_I;
  bit         m_ir [$];
  bit         m_dr [$];
  logic       m_tdo = 1'b0;
  logic       m_en  = 1'b0;

  initial begin
    int k;
    forever begin
      @(posedge clk or negedge clk or negedge trst);
      k = dr_kind(m_instr);
      if (!trst) begin
        m_state = ST_TLR;
        m_instr = RST_I;
        m_ir = {};
        for (int i = 0; i < IR_W; i++) m_ir.push_back(CAP[i]);
        m_tdo = 1'b0;
        m_en  = 1'b0;
      end else if (clk) begin
        if (m_state == ST_CAPIR) begin
          m_ir = {};
          for (int i = 0; i < IR_W; i++) m_ir.push_back(CAP[i]);
        end else if (m_state == ST_SHIR) begin
          void'(m_ir.pop_front());
          m_ir.push_back(tdi);
        end
        if (m_state == ST_CAPDR && k == -1) m_dr = '{1'b0};
        if (m_state == ST_CAPDR && k == -2) begin
          m_dr = {};
          for (int i = 0; i < 32; i++) m_dr.push_back(IDV[i]);
        end
        if (m_state == ST_SHDR && k < 0) begin
          void'(m_dr.pop_front());
          m_dr.push_back(tdi);
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
      end else begin
        m_en  = (m_state == ST_SHIR) || (m_state == ST_SHDR);
        m_tdo = 1'b0;
        if (m_state == ST_SHIR) m_tdo = m_ir[0];
        if (m_state == ST_SHDR) m_tdo = (k >= 0) ? user_tdo[k] : m_dr[0];
        if (m_state == ST_UPIR) for (int i = 0; i < IR_W; i++) m_instr[i] = m_ir[i];
        if (m_state == ST_TLR)  m_instr = RST_I;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("tstate", 32'(tstate), 32'(m_state));
      chk("instr", 32'(instr), 32'(m_instr));
      chk("user_sel", 32'(user_sel), 32'(exp_sel(m_instr)));
      chk("tdo", 32'(tdo), 32'(m_tdo));
      chk("tdo_en", 32'(tdo_en), 32'(m_en));
      chk("capture_dr", 32'(capture_dr), 32'(m_state == ST_CAPDR));
      chk("shift_dr", 32'(shift_dr), 32'(m_state == ST_SHDR));
      chk("update_dr_low", 32'(update_dr), 32'(m_state == ST_UPDR));
      chk("reset_n", 32'(reset_n), 32'(trst && m_state != ST_TLR));
      @(posedge clk);
      #1;
      chk("update_dr_high", 32'(update_dr), 32'd0);
    end
  end

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(negedge clk);
    #2;
  endtask

  task automatic ir_scan(input logic [3:0] op, output logic [3:0] seen);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      seen[i] = tdo;
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] pat;
    logic [3:0]  seen;
    logic [3:0]  seq;
    logic [4:0]  bits;
    int          en_cnt;

    #1 trst = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_tstate", 32'(tstate), 32'hF);
    chk("rst_instr", 32'(instr), 32'(RST_I));
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_reset_n", 32'(reset_n), 32'd0);
    chk("rst_ir_sh", 32'(dut.r_ir_sh), 32'(CAP));
    trst = 1'b1;

    step(1'b0, 1'b0);
    chk("idle_tstate", 32'(tstate), 32'hC);
    chk("idle_reset_n", 32'(reset_n), 32'd1);

    // First DR scan after reset: IDCODE or single bypass bit
    pat = 32'hC3A5_0F69;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    word = '0;
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      word[i] = tdo;
      en_cnt += int'(tdo_en);
      step(i == 31, pat[i]);
    end
    chk("first_dr_word", word, HAS_ID ? IDV : {pat[30:0], 1'b0});
    chk("dr_en_count", 32'(en_cnt), 32'd32);
    chk("ex1dr_tdo_en", 32'(tdo_en), 32'd0);

    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("back_in_shdr", 32'(tstate), 32'h2);
    repeat (5) step(1'b1, 1'b0);
    chk("five_tms_tlr", 32'(tstate), 32'hF);

    step(1'b0, 1'b0);
    ir_scan(4'hF, seen);
    chk("ir_capture_bits", 32'(seen), 32'h1);
    chk("instr_bypass", 32'(instr), 32'hF);

    seq = 4'b1101;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bits[i] = tdo;
      step(i == 4, (i < 4) ? seq[i] : 1'b0);
    end
    chk("bypass_bits", 32'(bits), 32'b11010);
    step(1'b1, 1'b0);
    chk("update_dr_pulse", 32'(update_dr), 32'd1);
    step(1'b0, 1'b0);

    ir_scan(4'h9, seen);
    chk("instr_user1", 32'(instr), 32'h9);
    chk("user_sel_10", 32'(user_sel), 32'b10);

    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      user_tdo = {i[0], ~i[0]};
      step(i == 7, 1'b0);
      if (i < 7) chk("user_tdo_follow", 32'(tdo), 32'(user_tdo[1]));
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Abort an IR scan halfway through
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    chk("mid_shir_state", 32'(tstate), 32'hA);
    trst = 1'b0;
    #1;
    chk("abort_tstate", 32'(tstate), 32'hF);
    chk("abort_instr", 32'(instr), 32'(RST_I));
    chk("abort_ir_sh", 32'(dut.r_ir_sh), 32'(CAP));
    chk("abort_tdo_en", 32'(tdo_en), 32'd0);
    chk("abort_tdo", 32'(tdo), 32'd0);
    tms = 1'b1;
    trst = 1'b1;
    @(negedge clk);
    #2;
    chk("post_abort_tlr", 32'(tstate), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_tap_core.md
Name: jtag_tap_core

Overview:
- Parametrised next-generation JTAG TAP: IEEE 1149.1 16-state controller plus an internal instruction register, instruction decode, BYPASS and IDCODE data registers, NUM_USER external data-register selects, and a registered TDO mux.
- Sits between the USB-JTAG bridge pins (TCK = clk) and the fabric's user scan chains.
- Replaces per-design hand-wired IR/DR glue.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IR_CAPTURE, {IR_WIDTH-2 zeros, 2'b01}, value loaded into IR shift stage in Capture-IR
IDCODE_VALUE, 32'h4A55_B001, IDCODE register contents (bit0 must be 1)
IDCODE_INSTR, 1, opcode selecting IDCODE
USER_BASE, 8, opcode of user DR 0; user DR i uses USER_BASE+i
NUM_USER, 2, number of external user data registers (1..8)

Ports:
clk  in  1  TCK
trst  in  1  async active-low TAP reset
tms  in  1  test mode select
tdi  in  1  test data in
tdo  out  1  test data out, registered on falling clk
tdo_en  out  1  high while TDO data is valid (Shift-IR/Shift-DR)
tstate  out  4  current state, encoded 0xF TLR, 0xC IDLE, 0x7 SELDR, 0x6 CAPDR, 0x2 SHDR, 0x1 EX1DR, 0x3 PDR, 0x0 EX2DR, 0x5 UPDR, 0x4 SELIR, 0xE CAPIR, 0xA SHIR, 0x9 EX1IR, 0xB PIR, 0x8 EX2IR, 0xD UPIR
instr  out  IR_WIDTH  active instruction
user_sel  out  NUM_USER  one-hot user DR select, decoded from instr
capture_dr  out  1  state == CAPDR
shift_dr  out  1  state == SHDR
update_dr  out  1  state == UPDR and clk low
user_tdo  in  NUM_USER  serial output (LSB) of each user DR
reset_n  out  1  low in TLR or when trst low

Behaviour:
- Reset: trst low asynchronously forces state TLR; IR shift stage = IR_CAPTURE; instr = IDCODE_INSTR; bypass = 0; tdo = 0; tdo_en = 0.
- FSM: standard 1149.1 transitions on rising clk. Five consecutive tms=1 reach TLR from any state. No separate timeout counter.
- While in TLR, instr is reloaded to the reset instruction on each falling clk.
- IR path, rising clk:
  - CAPIR: ir_sh <= IR_CAPTURE.
  - SHIR: ir_sh <= {tdi, ir_sh[IR_WIDTH-1:1]}.
  - Falling clk in UPIR: instr <= ir_sh. Instr is otherwise stable through all DR states.
- Decode:
  - All-ones opcode: BYPASS.
  - IDCODE_INSTR: IDCODE.
  - USER_BASE+i, i < NUM_USER: user_sel[i] = 1.
  - Any other opcode: BYPASS.
  - At most one user_sel bit set; all zero when BYPASS or IDCODE.
- BYPASS, rising clk: CAPDR loads 0; SHDR loads tdi. Exactly one-cycle tdi-to-tdo delay.
- IDCODE, rising clk: CAPDR loads IDCODE_VALUE; SHDR shifts right with tdi into bit31.
- User DRs: this block only supplies strobes and user_sel. The user register shifts on rising clk when shift_dr & user_sel[i].
- TDO, falling clk:
  - SHIR: tdo <= ir_sh[0].
  - SHDR: tdo <= LSB of the selected DR.
  - tdo_en <= (SHIR or SHDR).
  - Elsewhere tdo <= 0, tdo_en <= 0.
- Only the selected DR's shift stage changes during SHDR. IR shift stage is untouched during DR scans.
- trst low mid-scan: immediate abort to reset values. No partial update of instr.

Optional Feature:
- JTAG_IDCODE_EN defined: IDCODE register present; reset instruction = IDCODE_INSTR.
- Not defined: no IDCODE register; IDCODE_INSTR decodes as BYPASS; reset instruction = all ones (BYPASS). After reset, a DR scan returns a single 0 then tdi delayed by one cycle.

Test Plan:
- trst low 1 cycle -> tstate 0xF, instr 4'h1, tdo_en 0, reset_n 0. Then tms=0 -> tstate 0xC, reset_n 1.
- From SHDR, drive tms=1 for 5 clocks -> tstate 0xF after the 5th rising edge.
- Reset, go to SHDR, 32 shifts with tdi=0 -> tdo serial LSB-first 32'h4A55_B001; tdo_en 1 for exactly those 32 bits.
- IR scan shifting 4'hF -> tdo shows capture 0001 LSB-first; after UPIR instr=4'hF. A DR scan of pattern 1011 -> tdo 0 then 1011.
- IR scan 4'h9 -> user_sel=2'b10. DR scan with user_tdo[1] toggling -> tdo follows user_tdo[1]. shift_dr high only in SHDR; update_dr pulses during clk-low of UPDR.
- Assert trst mid SHIR after 2 of 4 bits -> tstate 0xF, instr unchanged reset value 4'h1, ir_sh = IR_CAPTURE. Repeat with JTAG_IDCODE_EN undefined -> reset instr 4'hF.
